// File: rtl/ov7670_sccb_config.sv
// -----------------------------------------------------------------------------
// ov7670_sccb_config
//   Write-only SCCB master that programs the OV7670 from an external register
//   table before capture. After i_start it waits for sensor power-up, then walks
//   the table: each {reg,value} entry becomes one 3-phase write (device id,
//   register, value). 16'hFFF0 inserts a MARK_DELAY pause, 16'hFFFF ends the
//   table, and the last table address is treated as the end if no marker is met.
//
// Ports
//   clk           system clock
//   system_reset  asynchronous, active-low reset
//   i_start       1-clk pulse, begin configuration from entry 0 (ignored while busy)
//   o_rom_addr    table index to the synchronous ROM
//   i_rom_data    {reg_addr[15:8], value[7:0]}, valid 1 clk after o_rom_addr
//   o_sioc        SCCB clock, push-pull
//   o_siod_oe     1 = pull SIOD low, 0 = release to the external pull-up
//   i_siod_in     SIOD pad readback (ACK sampling only)
//   o_busy        configuration sequence in progress
//   o_done        sticky, table completed without error
//   o_error       sticky, NACK seen (constant 0 unless ACK checking is built)
//   o_reg_count   number of register writes completed
//
// Build option
//   SCCB_ACK_CHECK_EN  when defined, SIOD is sampled in the three ACK slots of
//                      every write; a NACK finishes the STOP and then aborts
//                      with o_error set. When undefined, ACK slots are ignored.
// -----------------------------------------------------------------------------
module ov7670_sccb_config #(
  parameter int          CLK_FREQ_HZ  = 27_000_000,
  parameter int          SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter logic [23:0] PWR_DELAY    = 24'd270_000,
  parameter logic [23:0] MARK_DELAY   = 24'd270_000,
  parameter int          GAP_QTRS     = 4,
  parameter int          ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              system_reset,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_sioc,
  output logic              o_siod_oe,
  input  logic              i_siod_in,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_reg_count
);

  // Clocks per quarter SIOC period; every bus phase is a whole number of quarters.
  localparam int             QTR      = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int             QW       = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0]  QTR_LAST = QW'(QTR - 1);
  localparam logic [7:0]     GAP_LAST = 8'(GAP_QTRS - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PWR_WAIT = 4'd1;
  localparam logic [3:0] S_FETCH    = 4'd2;
  localparam logic [3:0] S_START    = 4'd3;
  localparam logic [3:0] S_BITS     = 4'd4;
  localparam logic [3:0] S_STOP     = 4'd5;
  localparam logic [3:0] S_GAP      = 4'd6;
  localparam logic [3:0] S_DELAY    = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
`ifdef SCCB_ACK_CHECK_EN
  localparam logic [3:0] S_ERROR    = 4'd9;
`endif

  logic [3:0]        r_state;
  logic [QW-1:0]     r_qcnt;       // clk within the current quarter
  logic [7:0]        r_qph;        // quarter within the current phase
  logic [4:0]        r_bit;        // bit index 0..26 within the frame
  logic [26:0]       r_shift;      // frame, MSB goes out first
  logic [23:0]       r_dly;
  logic              r_fcnt;       // FETCH: 0 = address settling, 1 = data valid
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_reg_count;
  logic              r_busy;
  logic              r_done;
  logic              r_sioc;
  logic              r_siod_oe;
  logic              w_sioc;
  logic              w_siod_oe;
  logic              w_timed;
  logic              w_qtick;
  logic              w_last_addr;
  logic [23:0]       w_dly_next;

  assign w_timed     = (r_state == S_START) || (r_state == S_BITS) ||
                       (r_state == S_STOP)  || (r_state == S_GAP);
  assign w_qtick     = w_timed && (r_qcnt == QTR_LAST);
  assign w_last_addr = &r_rom_addr;
  assign w_dly_next  = r_dly + 24'd1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset)            r_qcnt <= '0;
    else if (w_timed && !w_qtick) r_qcnt <= r_qcnt + 1'b1;
    else                          r_qcnt <= '0;
  end

`ifdef SCCB_ACK_CHECK_EN
  logic r_error;
  logic r_nack;
  logic w_ack_slot;
  assign w_ack_slot = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);
  assign o_error    = r_error;

  // Sample the slave at the end of q2, with SIOC high and the line settled.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset)                 r_nack <= 1'b0;
    else if (r_state == S_START)       r_nack <= 1'b0;
    else if (r_state == S_BITS && w_qtick && r_qph == 8'd2 && w_ack_slot && i_siod_in)
                                       r_nack <= 1'b1;
  end
`else
  // ACK slots are don't-care; SIOD readback is intentionally left unused.
  logic w_unused;
  assign w_unused = i_siod_in;
  assign o_error  = 1'b0;
`endif

  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      r_state     <= S_IDLE;
      r_qph       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_dly       <= '0;
      r_fcnt      <= 1'b0;
      r_rom_addr  <= '0;
      r_reg_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
      r_error     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_done      <= 1'b0;
          r_rom_addr  <= '0;
          r_reg_count <= '0;
          r_busy      <= 1'b1;
          r_dly       <= '0;
`ifdef SCCB_ACK_CHECK_EN
          r_error     <= 1'b0;
`endif
          r_state     <= S_PWR_WAIT;
        end
        S_PWR_WAIT: begin
          r_dly <= w_dly_next;
          if (w_dly_next >= PWR_DELAY) begin
            r_fcnt  <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_fcnt <= ~r_fcnt;
          if (r_fcnt) begin
            if (i_rom_data == 16'hFFFF) begin
              r_state <= S_DONE;
            end else if (i_rom_data == 16'hFFF0) begin
              r_dly   <= '0;
              r_state <= S_DELAY;
            end else begin
              // ACK slots carry 1 so the master releases SIOD for the slave.
              r_shift <= {DEV_ADDR, 1'b1, i_rom_data[15:8], 1'b1, i_rom_data[7:0], 1'b1};
              r_qph   <= '0;
              r_bit   <= '0;
              r_state <= S_START;
            end
          end
        end
        S_START: if (w_qtick) begin
          if (r_qph == 8'd1) begin
            r_qph   <= '0;
            r_state <= S_BITS;
          end else begin
            r_qph <= r_qph + 8'd1;
          end
        end
        S_BITS: if (w_qtick) begin
          if (r_qph == 8'd3) begin
            r_qph   <= '0;
            r_shift <= {r_shift[25:0], 1'b0};
            if (r_bit == 5'd26) r_state <= S_STOP;
            else                r_bit   <= r_bit + 5'd1;
          end else begin
            r_qph <= r_qph + 8'd1;
          end
        end
        S_STOP: if (w_qtick) begin
          if (r_qph == 8'd2) begin
            r_qph <= '0;
`ifdef SCCB_ACK_CHECK_EN
            if (r_nack) r_state <= S_ERROR;
            else
`endif
            begin
              r_reg_count <= r_reg_count + 1'b1;
              // Last table slot without an end marker ends the sequence.
              if (w_last_addr) begin
                r_state <= S_DONE;
              end else begin
                r_rom_addr <= r_rom_addr + 1'b1;
                r_state    <= S_GAP;
              end
            end
          end else begin
            r_qph <= r_qph + 8'd1;
          end
        end
        S_GAP: if (w_qtick) begin
          if (r_qph >= GAP_LAST) begin
            r_qph   <= '0;
            r_fcnt  <= 1'b0;
            r_state <= S_FETCH;
          end else begin
            r_qph <= r_qph + 8'd1;
          end
        end
        S_DELAY: begin
          r_dly <= w_dly_next;
          if (w_dly_next >= MARK_DELAY) begin
            if (w_last_addr) begin
              r_state <= S_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + 1'b1;
              r_fcnt     <= 1'b0;
              r_state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
`ifdef SCCB_ACK_CHECK_EN
        S_ERROR: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_error <= 1'b1;
          r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus levels by phase. START: q0 SIOD low under SIOC high, q1 SIOC low.
  // BITS: q0/q1 SIOC low with data set, q2/q3 SIOC high.
  // STOP: q0 both low, q1 SIOC high, q2 SIOD released.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_sioc    = 1'b1;
    w_siod_oe = 1'b0;
    case (r_state)
      S_START: begin
        w_sioc    = (r_qph == 8'd0);
        w_siod_oe = 1'b1;
      end
      S_BITS: begin
        w_sioc    = r_qph[1];
        w_siod_oe = ~r_shift[26];
      end
      S_STOP: begin
        w_sioc    = (r_qph != 8'd0);
        w_siod_oe = (r_qph != 8'd2);
      end
      default: ;
    endcase
  end

  // Registered pad drivers: glitch-free, and forced idle by reset immediately.
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      r_sioc    <= 1'b1;
      r_siod_oe <= 1'b0;
    end else begin
      r_sioc    <= w_sioc;
      r_siod_oe <= w_siod_oe;
    end
  end

  assign o_sioc      = r_sioc;
  assign o_siod_oe   = r_siod_oe;
  assign o_rom_addr  = r_rom_addr;
  assign o_reg_count = r_reg_count;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// -----------------------------------------------------------------------------
// tb_ov7670_sccb_config
//   Directed bench for ov7670_sccb_config. A small synchronous ROM model feeds
//   the table, and a passive SCCB slave model decodes START/bits/STOP from the
//   pads, ACKs the slave slots, and records each decoded {dev,reg,value} write.
//   Scaled parameters: QTR = 4 MHz / (4 * 100 kHz) = 10 clk, SIOC period 40 clk,
//   PWR_DELAY 200, MARK_DELAY 500, GAP_QTRS 4, ADDR_W 2 (4-entry table).
// -----------------------------------------------------------------------------
module tb_ov7670_sccb_config;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              system_reset;
  logic              i_start;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [15:0]       rom_q;
  logic              o_sioc;
  logic              o_siod_oe;
  logic              w_line;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic [ADDR_W-1:0] o_reg_count;
  logic              slave_drive = 1'b0;

  always #5 clk = ~clk;

  // Open-drain SIOD with pull-up: low if either side pulls it.
  assign w_line = ~o_siod_oe & ~slave_drive;

  ov7670_sccb_config #(
    .CLK_FREQ_HZ (4_000_000),
    .SCCB_FREQ_HZ(100_000),
    .DEV_ADDR    (8'h42),
    .PWR_DELAY   (24'd200),
    .MARK_DELAY  (24'd500),
    .GAP_QTRS    (4),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk         (clk),
    .system_reset(system_reset),
    .i_start     (i_start),
    .o_rom_addr  (o_rom_addr),
    .i_rom_data  (rom_q),
    .o_sioc      (o_sioc),
    .o_siod_oe   (o_siod_oe),
    .i_siod_in   (w_line),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_reg_count (o_reg_count)
  );

  logic [15:0] rom [4];
  always @(posedge clk) rom_q <= rom[o_rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SCCB slave / bus monitor ----------------
  logic        prev_sioc = 1'b1;
  logic        prev_line = 1'b1;
  logic        in_tx = 1'b0;
  logic        have_stop = 1'b0;
  logic        ack_en = 1'b1;
  logic        nack_en = 1'b0;
  int          nack_frame = 0;
  int          nack_bit = 17;
  int          nbits = 0;
  logic [26:0] shreg = '0;
  logic [23:0] writes[$];
  int          n_starts, n_stops, bad_frames, frame_idx;
  int          start_cyc, last_stop_cyc, last_gap, tx_len, last_rise, min_per, max_per;

  always @(negedge clk) begin
    if (!system_reset) begin
      in_tx       = 1'b0;
      nbits       = 0;
      slave_drive = 1'b0;
    end else begin
      if (o_sioc && prev_sioc && prev_line && !w_line) begin
        if (in_tx) bad_frames++;
        in_tx     = 1'b1;
        nbits     = 0;
        shreg     = '0;
        start_cyc = cyc;
        n_starts++;
        if (have_stop) last_gap = cyc - last_stop_cyc;
      end else if (o_sioc && prev_sioc && !prev_line && w_line) begin
        if (in_tx && nbits == 27) writes.push_back({shreg[26:19], shreg[17:10], shreg[8:1]});
        else                      bad_frames++;
        if (in_tx) begin
          tx_len = cyc - start_cyc;
          frame_idx++;
        end
        n_stops++;
        in_tx         = 1'b0;
        have_stop     = 1'b1;
        last_stop_cyc = cyc;
      end
      if (o_sioc && !prev_sioc && in_tx && nbits < 27) begin
        shreg = {shreg[25:0], w_line};
        if (nbits > 0) begin
          if (cyc - last_rise < min_per) min_per = cyc - last_rise;
          if (cyc - last_rise > max_per) max_per = cyc - last_rise;
        end
        last_rise = cyc;
        nbits++;
      end
      if (!o_sioc && prev_sioc && in_tx)
        slave_drive = ack_en && (nbits == 8 || nbits == 17 || nbits == 26) &&
                      !(nack_en && frame_idx == nack_frame && nbits == nack_bit);
    end
    prev_sioc = o_sioc;
    prev_line = w_line;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] wr(input int i);
    return (writes.size() > i) ? writes[i] : 24'hxxxxxx;
  endfunction

  task automatic clear_mon();
    writes.delete();
    n_starts   = 0;
    n_stops    = 0;
    bad_frames = 0;
    frame_idx  = 0;
    have_stop  = 1'b0;
    last_gap   = 0;
    tx_len     = 0;
    min_per    = 1_000_000;
    max_per    = 0;
  endtask

  task automatic load_rom(input logic [15:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int c = 0;
    while (!((o_done || o_error) && !o_busy) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, ((o_done || o_error) && !o_busy), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int off [4];
    int inj;
    int c;

    system_reset = 1'b0;
    i_start      = 1'b0;
    load_rom(16'h1100, 16'h1100, 16'h1100, 16'h1100);
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sioc",  o_sioc,      1);
    check("rst_oe",    o_siod_oe,   0);
    check("rst_busy",  o_busy,      0);
    check("rst_done",  o_done,      0);
    check("rst_error", o_error,     0);
    check("rst_addr",  o_rom_addr,  0);
    check("rst_cnt",   o_reg_count, 0);
    system_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T2: two writes separated by a delay marker
    load_rom(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
    clear_mon();
    pulse_start();
    check("t2_busy", o_busy, 1);
    wait_end("t2_end", 6000);
    check("t2_nwr",  writes.size(), 2);
    check("t2_w0",   wr(0), 24'h421280);
    check("t2_w1",   wr(1), 24'h421101);
    check("t2_gap",  (last_gap >= 500), 1);
    check("t2_done", o_done, 1);
    check("t2_busy_end", o_busy, 0);
    check("t2_cnt",  o_reg_count, 2);
    check("t2_err",  o_error, 0);
    check("t2_bad",  bad_frames, 0);

    // T3: single write, bit timing (period 4*10 clk; START-fall to STOP-rise
    // spans 2 + 27*4 + 2 quarters = 112 * 10 clk)
    load_rom(16'h3A04, 16'hFFFF, 16'h1100, 16'h1100);
    clear_mon();
    pulse_start();
    wait_end("t3_end", 4000);
    check("t3_nwr",    writes.size(), 1);
    check("t3_w0",     wr(0), 24'h423A04);
    check("t3_minper", min_per, 40);
    check("t3_maxper", max_per, 40);
    check("t3_txlen",  tx_len, 1120);
    check("t3_starts", n_starts, 1);
    check("t3_stops",  n_stops, 1);
    check("t3_bad",    bad_frames, 0);
    check("t3_cnt",    o_reg_count, 1);

    // T4: T2 table with extra start pulses while busy
    load_rom(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
    clear_mon();
    for (int i = 0; i < 4; i++) off[i] = i * 700 + $urandom_range(1, 600);
    pulse_start();
    inj = 0;
    c = 0;
    while (!(o_done && !o_busy) && c < 6000) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int i = 0; i < 4; i++)
        if (c == off[i] && o_busy) begin
          i_start = 1'b1;
          inj++;
        end
      c++;
    end
    i_start = 1'b0;
    check("t4_end",    (o_done && !o_busy), 1);
    check("t4_inj",    inj, 4);
    check("t4_nwr",    writes.size(), 2);
    check("t4_w0",     wr(0), 24'h421280);
    check("t4_w1",     wr(1), 24'h421101);
    check("t4_starts", n_starts, 2);
    check("t4_cnt",    o_reg_count, 2);

    // T1: asynchronous reset in bit 5 of the second write
    load_rom(16'h1100, 16'h1100, 16'h1100, 16'h1100);
    clear_mon();
    pulse_start();
    c = 0;
    while (!(writes.size() == 1 && in_tx && nbits == 5) && c < 4000) begin
      @(posedge clk); #1;
      c++;
    end
    check("t1_reach",   (writes.size() == 1 && in_tx && nbits == 5), 1);
    check("t1_pre_cnt", o_reg_count, 1);
    #3 system_reset = 1'b0;
    #1;
    check("t1_sioc", o_sioc, 1);
    check("t1_oe",   o_siod_oe, 0);
    check("t1_busy", o_busy, 0);
    check("t1_cnt",  o_reg_count, 0);
    check("t1_addr", o_rom_addr, 0);
    @(posedge clk); #1 system_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T6: no end marker, 4-entry table: four writes then done; the 2-bit
    // write counter wraps 4 -> 0
    clear_mon();
    pulse_start();
    wait_end("t6_end", 8000);
    check("t6_nwr", writes.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t6_w%0d", i), wr(i), 24'h421100);
    check("t6_done", o_done, 1);
    check("t6_cnt",  o_reg_count, 0);
    check("t6_bad",  bad_frames, 0);

`ifdef SCCB_ACK_CHECK_EN
    // T5: slave NACKs the register byte of write 0, then a clean retry
    load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    clear_mon();
    nack_en    = 1'b1;
    nack_frame = 0;
    nack_bit   = 17;
    pulse_start();
    wait_end("t5_end", 4000);
    check("t5_err",   o_error, 1);
    check("t5_done",  o_done, 0);
    check("t5_cnt",   o_reg_count, 0);
    check("t5_stops", n_stops, 1);
    nack_en = 1'b0;
    clear_mon();
    pulse_start();
    wait_end("t5_retry_end", 6000);
    check("t5_retry_done", o_done, 1);
    check("t5_retry_err",  o_error, 0);
    check("t5_retry_cnt",  o_reg_count, 2);
    check("t5_retry_nwr",  writes.size(), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
